// File: rtl/timing_sequencer_if.sv
// Bundle of the control inputs and status outputs of the instruction
// timing sequencer. The clock and reset stay outside as plain ports.
interface timing_sequencer_if #(
  parameter int T_STATES = 4,
  parameter int ICNT_W   = 16
);
  localparam int TC_W = (T_STATES > 2) ? $clog2(T_STATES) : 1;

  // Control inputs toward the sequencer
  logic              hlt;
  logic              clr_timer;
  logic              wait_req;
  logic              resume;
  logic              step_mode;
  logic              step;

  // Status outputs from the sequencer
  logic [TC_W-1:0]     time_cycle;
  logic [T_STATES-1:0] T;
  logic                halted;
  logic                instr_done;
  logic [ICNT_W-1:0]   instr_count;
  logic                overrun;

  // The sequencer itself
  modport slave (
    input  hlt, clr_timer, wait_req, resume, step_mode, step,
    output time_cycle, T, halted, instr_done, instr_count, overrun
  );

  // Whatever drives the control inputs (CPU control unit, testbench)
  modport master (
    output hlt, clr_timer, wait_req, resume, step_mode, step,
    input  time_cycle, T, halted, instr_done, instr_count, overrun
  );
endinterface

// File: rtl/timing_sequencer.sv
// Instruction timing sequencer: steps through T-states T0..T(n-1) per
// instruction, with wait-state stalls, halt/resume, early end-of-instruction
// and single-instruction stepping. All outputs are registered.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | one cycle after reset release, T all zero
// S_RUN       | executing, T one-hot at time_cycle
// S_HALT      | halted, T all zero, time_cycle frozen where hlt hit
// S_STEP_WAIT | stepping, instruction retired, waiting for a step pulse
module timing_sequencer #(
  parameter int T_STATES = 4,
  parameter int ICNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  timing_sequencer_if.slave   bus
);

  localparam int TC_W = (T_STATES > 2) ? $clog2(T_STATES) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(T_STATES - 1);
  localparam logic [TC_W-1:0] TC_ZERO = '0;
  localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);
  localparam logic [ICNT_W-1:0] CNT_ONE = ICNT_W'(1);
  localparam logic [T_STATES-1:0] T_ONE = T_STATES'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_HALT      = 2'd2,
    S_STEP_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TC_W-1:0]     tc_q, tc_d;
  logic [T_STATES-1:0] t_q, t_d;
  logic                halted_q, halted_d;
  logic                done_q, done_d;
  logic [ICNT_W-1:0]   cnt_q, cnt_d;
  logic                ovr_q, ovr_d;

  logic hlt_i, clr_timer_i, wait_req_i, resume_i, step_mode_i, step_i;
  logic at_last;
  logic end_of_instr;

  assign hlt_i       = bus.hlt;
  assign clr_timer_i = bus.clr_timer;
  assign wait_req_i  = bus.wait_req;
  assign resume_i    = bus.resume;
  assign step_mode_i = bus.step_mode;
  assign step_i      = bus.step;

  assign at_last      = (tc_q == TC_LAST);
  assign end_of_instr = clr_timer_i || at_last;

  // Next-state and counter update; RUN priority is wait, halt, end, advance
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
        tc_d    = TC_ZERO;
      end

      S_RUN: begin
        if (wait_req_i) begin
          state_d = S_RUN;
        end else if (hlt_i) begin
          state_d = S_HALT;
        end else if (end_of_instr) begin
          tc_d   = TC_ZERO;
          done_d = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
          // Running off the end without the control unit closing the
          // instruction means the microcode needed more T-states.
          if (!clr_timer_i) begin
            ovr_d = 1'b1;
          end
          state_d = step_mode_i ? S_STEP_WAIT : S_RUN;
        end else begin
          tc_d = tc_q + TC_ONE;
        end
      end

      S_HALT: begin
        if (resume_i && !hlt_i) begin
          state_d = S_RUN;
          tc_d    = TC_ZERO;
        end
      end

      S_STEP_WAIT: begin
        tc_d = TC_ZERO;
        if (step_i || !step_mode_i) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
        tc_d    = TC_ZERO;
      end
    endcase
  end

  // Output decode from the next state so T/halted register in step with it
  always_comb begin
    t_d      = '0;
    halted_d = 1'b0;
    if (state_d == S_RUN) begin
      t_d = T_ONE << tc_d;
    end
    if (state_d == S_HALT) begin
      halted_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tc_q     <= TC_ZERO;
      t_q      <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
      t_q      <= t_d;
      halted_q <= halted_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.time_cycle  = tc_q;
  assign bus.T           = t_q;
  assign bus.halted      = halted_q;
  assign bus.instr_done  = done_q;
  assign bus.instr_count = cnt_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed scenarios followed by random stimulus, each cycle compared
// against a behavioural model of the sequencer.
module tb_timing_sequencer;
  localparam int NT = 4;
  localparam int IW = 16;
  localparam int CNT_MOD = 1 << IW;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_STEP = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  timing_sequencer_if #(.T_STATES(NT), .ICNT_W(IW)) bus ();

  timing_sequencer #(.T_STATES(NT), .ICNT_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  int m_mode  = M_IDLE;
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_ov    = 1'b0;
  bit m_done  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit h, input bit c, input bit w, input bit r, input bit sm, input bit st);
    bus.hlt       = h;
    bus.clr_timer = c;
    bus.wait_req  = w;
    bus.resume    = r;
    bus.step_mode = sm;
    bus.step      = st;
  endtask

  // One clock of the reference behaviour, using the inputs seen at the edge
  task automatic model_step();
    bit eoi;
    if (reset) begin
      m_mode = M_IDLE; m_phase = 0; m_cnt = 0; m_ov = 0; m_done = 0;
      return;
    end
    m_done = 0;
    case (m_mode)
      M_IDLE: begin m_mode = M_RUN; m_phase = 0; end
      M_RUN: begin
        eoi = bus.clr_timer || (m_phase == NT - 1);
        if (bus.wait_req) begin
        end else if (bus.hlt) begin
          m_mode = M_HALT;
        end else if (eoi) begin
          if (!bus.clr_timer) m_ov = 1;
          m_cnt   = (m_cnt + 1) % CNT_MOD;
          m_done  = 1;
          m_phase = 0;
          if (bus.step_mode) m_mode = M_STEP;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      M_HALT: if (bus.resume && !bus.hlt) begin m_mode = M_RUN; m_phase = 0; end
      default: begin
        m_phase = 0;
        if (bus.step || !bus.step_mode) m_mode = M_RUN;
      end
    endcase
  endtask

  task automatic check_all();
    int exp_t;
    exp_t = (m_mode == M_RUN) ? (1 << m_phase) : 0;
    check("T",           32'(bus.T),           32'(exp_t));
    check("time_cycle",  32'(bus.time_cycle),  32'(m_phase));
    check("halted",      32'(bus.halted),      32'(m_mode == M_HALT));
    check("instr_done",  32'(bus.instr_done),  32'(m_done));
    check("instr_count", 32'(bus.instr_count), 32'(m_cnt));
    check("overrun",     32'(bus.overrun),     32'(m_ov));
    check("T_onehot",    32'($countones(bus.T) <= 1), 32'd1);
  endtask

  task automatic tick(input bit full);
    @(posedge clk);
    model_step();
    #1;
    if (full) check_all();
  endtask

  int snap;
  int guard;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    tick(1); tick(1);
    check("rst_T", 32'(bus.T), 32'd0);
    check("rst_count", 32'(bus.instr_count), 32'd0);

    // Free run with no control: one idle cycle, then T0..T3 and wrap
    reset = 1'b0;
    check("idle_T", 32'(bus.T), 32'd0);
    tick(1); check("run_T0", 32'(bus.T), 32'b0001);
    tick(1); check("run_T1", 32'(bus.T), 32'b0010);
    tick(1); check("run_T2", 32'(bus.T), 32'b0100);
    tick(1); check("run_T3", 32'(bus.T), 32'b1000);
    check("no_done_T3", 32'(bus.instr_done), 32'd0);
    tick(1); check("wrap_T", 32'(bus.T), 32'b0001);
    check("wrap_done", 32'(bus.instr_done), 32'd1);
    check("wrap_ovr", 32'(bus.overrun), 32'd1);
    tick(1); check("ovr_sticky", 32'(bus.overrun), 32'd1);
    check("done_pulse", 32'(bus.instr_done), 32'd0);

    // Early end-of-instruction at T1
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(1); tick(1);
    check("pre_clr_T1", 32'(bus.T), 32'b0010);
    drive(0, 1, 0, 0, 0, 0); tick(1); drive(0, 0, 0, 0, 0, 0);
    check("clr_T", 32'(bus.T), 32'b0001);
    check("clr_done", 32'(bus.instr_done), 32'd1);
    check("clr_count", 32'(bus.instr_count), 32'd1);
    check("clr_no_ovr", 32'(bus.overrun), 32'd0);
    tick(1);
    check("clr_done_off", 32'(bus.instr_done), 32'd0);

    // Three-cycle wait stall at T1
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_T", 32'(bus.T), 32'b0010);
      check("stall_done", 32'(bus.instr_done), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0); tick(1);
    check("after_stall", 32'(bus.T), 32'b0100);

    // Halt at T2, resume blocked by hlt, then resume
    drive(1, 0, 0, 0, 0, 0); tick(1);
    check("halt_h", 32'(bus.halted), 32'd1);
    check("halt_T", 32'(bus.T), 32'd0);
    drive(1, 0, 0, 1, 0, 0); tick(1);
    check("halt_hold", 32'(bus.halted), 32'd1);
    drive(0, 0, 0, 1, 0, 0); tick(1);
    drive(0, 0, 0, 0, 0, 0);
    check("resume_T", 32'(bus.T), 32'b0001);
    check("resume_h", 32'(bus.halted), 32'd0);

    // Single-step mode
    drive(0, 0, 0, 0, 1, 0); tick(1);
    drive(0, 1, 0, 0, 1, 0); tick(1);
    drive(0, 0, 0, 0, 1, 0);
    check("step_wait_T", 32'(bus.T), 32'd0);
    snap = int'(bus.instr_count);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("step_idle_T", 32'(bus.T), 32'd0);
    end
    for (int s = 0; s < 3; s++) begin
      drive(0, 0, 0, 0, 1, 1); tick(1); drive(0, 0, 0, 0, 1, 0);
      check("step_go_T", 32'(bus.T), 32'b0001);
      for (int i = 0; i < 4; i++) tick(1);
      check("step_parked", 32'(bus.T), 32'd0);
      check("step_count", 32'(bus.instr_count), 32'((snap + s + 1) % CNT_MOD));
    end
    drive(0, 0, 0, 0, 0, 0); tick(1);
    check("step_exit_T", 32'(bus.T), 32'b0001);

    // Counter wrap, then reset in the middle of an instruction
    reset = 1'b1; tick(1); reset = 1'b0;
    drive(0, 1, 0, 0, 0, 0);
    tick(0);
    guard = 0;
    while (m_cnt != CNT_MOD - 1 && guard < 70000) begin
      tick(0);
      guard++;
    end
    check("preload_bound", 32'(guard < 70000), 32'd1);
    check("cnt_ffff", 32'(bus.instr_count), 32'hFFFF);
    tick(1);
    check("cnt_wrap", 32'(bus.instr_count), 32'h0000);
    drive(0, 0, 0, 0, 0, 0);
    tick(1); tick(1);
    check("pre_rst_T2", 32'(bus.T), 32'b0100);
    reset = 1'b1; tick(1);
    check("mid_rst_T", 32'(bus.T), 32'd0);
    check("mid_rst_tc", 32'(bus.time_cycle), 32'd0);
    check("mid_rst_cnt", 32'(bus.instr_count), 32'd0);
    check("mid_rst_h", 32'(bus.halted), 32'd0);
    check("mid_rst_done", 32'(bus.instr_done), 32'd0);
    check("mid_rst_ovr", 32'(bus.overrun), 32'd0);
    reset = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 SHALL have parameter T_STATES, default 4, meaning number of T-states per instruction; legal range 2..16.
REQ-002 SHALL have parameter ICNT_W, default 16, meaning width of the retired-instruction counter.
REQ-003 SHALL derive localparam TC_W = ceil(log2(T_STATES)), minimum 1, as the time_cycle width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port hlt, input, 1 bit: halt request from the control bus or an external source.
REQ-007 SHALL have port clr_timer, input, 1 bit: early end-of-instruction; return to T0 next cycle.
REQ-008 SHALL have port wait_req, input, 1 bit: memory/IO not ready; freeze the current T-state.
REQ-009 SHALL have port resume, input, 1 bit: leave HALT.
REQ-010 SHALL have port step_mode, input, 1 bit: enables single-instruction stepping.
REQ-011 SHALL have port step, input, 1 bit: advance one instruction while stepping.
REQ-012 SHALL have port time_cycle, output, TC_W bits: current T-state index.
REQ-013 SHALL have port T, output, T_STATES bits: one-hot T-state; all zero when not RUN.
REQ-014 SHALL have port halted, output, 1 bit: high while in HALT.
REQ-015 SHALL have port instr_done, output, 1 bit: one-cycle pulse per retired instruction.
REQ-016 SHALL have port instr_count, output, ICNT_W bits: retired-instruction count.
REQ-017 SHALL have port overrun, output, 1 bit: sticky; set when the last T-state is reached without clr_timer.

Function
REQ-018 SHALL implement states IDLE, RUN, HALT, STEP_WAIT; all outputs registered.
REQ-019 IDLE SHALL last exactly one cycle after reset deasserts, with T=0, then go to RUN with time_cycle=0.
REQ-020 In RUN, T SHALL equal 1<<time_cycle.
REQ-021 RUN event priority, highest first: wait_req, hlt, end-of-instruction, normal advance.
REQ-022 RUN with wait_req=1 SHALL hold time_cycle and state; instr_done SHALL be 0.
REQ-023 RUN with hlt=1 and wait_req=0 SHALL enter HALT next cycle with time_cycle held.
REQ-024 End-of-instruction is defined as clr_timer=1, or time_cycle=T_STATES-1.
REQ-025 On end-of-instruction, time_cycle SHALL go to 0 and instr_done SHALL be 1 on the following cycle only.
REQ-026 On end-of-instruction, instr_count SHALL increment modulo 2^ICNT_W.
REQ-027 On time_cycle=T_STATES-1 with clr_timer=0 (and wait_req=0, hlt=0), overrun SHALL set, and the sequencer SHALL still wrap to T0.
REQ-028 On end-of-instruction with step_mode=1, the sequencer SHALL enter STEP_WAIT instead of staying in RUN.
REQ-029 Otherwise RUN SHALL advance time_cycle by 1 per cycle.
REQ-030 In HALT, halted=1 and T=0.
REQ-031 HALT with resume=1 and hlt=0 SHALL go to RUN with time_cycle=0; with hlt=1 it SHALL remain in HALT.
REQ-032 In STEP_WAIT, T=0 and time_cycle=0.
REQ-033 STEP_WAIT with step=1, or step_mode=0, SHALL go to RUN at T0 the next cycle.
REQ-034 clr_timer, resume and step SHALL be ignored in states where they are not listed above.
REQ-035 At any time, at most one bit of T SHALL be high.

Reset
REQ-036 Reset values SHALL be: state=IDLE, time_cycle=0, T=0, halted=0, instr_done=0, instr_count=0, overrun=0.
REQ-037 reset SHALL take priority over every other input in every state, including mid-instruction and mid-stall.
REQ-038 overrun SHALL clear only on reset.

Verification (T_STATES=4, ICNT_W=16)
REQ-039 Scenario: release reset, all inputs 0 -> T=0000 for 1 cycle, then 0001,0010,0100,1000,0001; instr_done pulse after 1000; overrun=1.
REQ-040 Scenario: clr_timer=1 during T1 -> next T=0001; instr_done=1 for one cycle; instr_count=1; overrun=0.
REQ-041 Scenario: wait_req=1 for 3 cycles at T1 -> T=0010 held 4 cycles total; then 0100; no instr_done during the stall.
REQ-042 Scenario: hlt=1 at T2 -> halted=1 and T=0000 next cycle; resume with hlt=0 -> T=0001 next cycle; resume with hlt=1 -> stays halted.
REQ-043 Scenario: step_mode=1 and clr_timer at T1 -> STEP_WAIT with T=0000 until step pulses; then T=0001; instr_count increments by exactly 1 per step.
REQ-044 Scenario: instr_count preloaded to 0xFFFF by 65535 instructions, then one more retire -> instr_count=0x0000; reset asserted at T2 -> all outputs at reset values next cycle.
